pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised fetch-stage program-counter unit: owns the PC register, next-PC selection (sequential / redirect / hold) and the IF/ID PC pipeline register.
- Adds a halt state machine: a fetched halt can be cancelled by an older redirect, and the core stops only when the halt commits.
- Sits between the instruction memory address port and the decode stage. Stall and redirect come from the hazard unit and EX-stage branch resolution.

Parameters:
- PC_W, 16: PC width in bits.
- INC, 2: bytes per instruction. Must be a power of two, at least 1.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hazard-unit stall: hold PC and IF/ID.
- redirect  input  1  branch/jump taken or mispredict: load redirect_pc, flush IF/ID.
- redirect_pc  input  PC_W  redirect target.
- halt_if  input  1  instruction currently in IF decodes as halt.
- halt_commit  input  1  halt instruction has reached writeback.
- pc_if  output  PC_W  current fetch address (PC register).
- pc_inc_if  output  PC_W  pc_if + INC (combinational).
- pc_id  output  PC_W  PC of the instruction in ID.
- pc_inc_id  output  PC_W  pc_id + INC, registered.
- valid_id  output  1  ID holds a real instruction (0 = bubble).
- halted  output  1  core halted; terminal until reset.

Behaviour:
- Reset (async, rst_n=0):
  - pc_if=RESET_PC; pc_id=0; pc_inc_id=0; valid_id=0; halted=0.
  - State goes to RUN. Reset mid-operation aborts everything immediately.
- Arithmetic:
  - pc_inc_if = pc_if + INC, modulo 2^PC_W. Wrap-around is silent, with no carry out.
  - The low log2(INC) bits of redirect_pc are forced to 0 on load.
- States: RUN, HALT_WAIT, HALTED. The state is encoded internally.
- Next-PC priority, per rising edge: halt_commit > redirect > stall > halt_if > increment.
- RUN:
  - redirect: pc_if<=aligned redirect_pc; valid_id<=0; pc_id and pc_inc_id unchanged. Redirect wins over a simultaneous stall or halt_if.
  - else stall: pc_if, pc_id, pc_inc_id and valid_id hold.
  - else halt_if: pc_if holds; IF/ID captures pc_if, pc_inc_if and valid_id=1 so the halt flows down the pipe; next state HALT_WAIT.
  - else: pc_if<=pc_inc_if; IF/ID captures pc_if, pc_inc_if and valid_id=1.
- HALT_WAIT:
  - pc_if frozen.
  - redirect: the halt was wrong-path; pc_if<=target; valid_id<=0; next state RUN.
  - else stall: IF/ID holds.
  - else: IF/ID loads a bubble (valid_id<=0); pc_id and pc_inc_id hold their values.
  - halt_if is ignored in this state.
- HALTED:
  - halted=1, registered and asserted the cycle after halt_commit.
  - pc_if frozen; valid_id<=0.
  - redirect, stall and halt_if are ignored. Only reset exits.
- halt_commit in any state: next state HALTED and valid_id<=0, even with a simultaneous redirect.
- Latency: pc_if changes exactly one edge after the qualifying input. No combinational path exists from the inputs to pc_if, pc_id or valid_id.
- halted=0 in RUN and HALT_WAIT.

Test Plan:
- Reset, then 4 free-running cycles with PC_W=16, INC=2, RESET_PC=0x0000 -> pc_if 0,2,4,6,8; pc_id 0,2,4,6 lagging one cycle; valid_id=1 after the first edge.
- Stall held 2 cycles at pc_if=0x0010 -> pc_if, pc_id and valid_id unchanged for 2 edges; on release pc_if=0x0012.
- Redirect and stall together, redirect_pc=0x0041 -> pc_if=0x0040 next edge; valid_id=0 for one cycle; then pc_id=0x0040.
- halt_if at pc_if=0x0020 -> pc_if stays 0x0020; pc_id=0x0020 with valid_id=1, then bubbles. Redirect to 0x0100 in HALT_WAIT -> RUN; sequence resumes 0x0100, 0x0102.
- halt_if, then halt_commit 3 cycles later with a redirect on the same edge -> halted=1 next edge; pc_if frozen; later redirects ignored. Asserting rst_n=0 mid-cycle -> pc_if=RESET_PC immediately and halted=0.
- PC_W=8, INC=4, pc_if=0xFC -> wraps to 0x00; pc_inc_if=0x00 at 0xFC.

Source files
------------

// File: rtl/pc_unit_if.sv
// Fetch-stage PC unit bus: control from hazard/EX/WB stages in, fetch and IF/ID PC state out.
interface pc_unit_if #(
    parameter int unsigned PC_W = 16
);
    logic            stall;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            halt_if;
    logic            halt_commit;
    logic [PC_W-1:0] pc_if;
    logic [PC_W-1:0] pc_inc_if;
    logic [PC_W-1:0] pc_id;
    logic [PC_W-1:0] pc_inc_id;
    logic            valid_id;
    logic            halted;

    modport master (
        output stall, redirect, redirect_pc, halt_if, halt_commit,
        input  pc_if, pc_inc_if, pc_id, pc_inc_id, valid_id, halted
    );

    modport slave (
        input  stall, redirect, redirect_pc, halt_if, halt_commit,
        output pc_if, pc_inc_if, pc_id, pc_inc_id, valid_id, halted
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter, next-PC selection, IF/ID PC register and halt state machine.
module pc_unit #(
    parameter int unsigned PC_W     = 16,
    parameter int unsigned INC      = 2,
    parameter int unsigned RESET_PC = 0
) (
    input logic      clk,
    input logic      rst_n,
    pc_unit_if.slave bus
);
    localparam int unsigned     AlignBits = (INC > 1) ? $clog2(INC) : 0;
    localparam logic [PC_W-1:0] IncVal    = PC_W'(INC);
    localparam logic [PC_W-1:0] AlignMask = ~PC_W'((64'd1 << AlignBits) - 64'd1);
    localparam logic [PC_W-1:0] ResetPc   = PC_W'(RESET_PC);

    typedef enum logic [1:0] {StRun, StHaltWait, StHalted} state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_id_q, pc_id_d;
    logic [PC_W-1:0] pc_inc_id_q, pc_inc_id_d;
    logic            valid_id_q, valid_id_d;
    logic            halted_q, halted_d;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] target;

    assign pc_inc = pc_q + IncVal;
    assign target = bus.redirect_pc & AlignMask;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc_id_d     = pc_id_q;
        pc_inc_id_d = pc_inc_id_q;
        valid_id_d  = valid_id_q;
        halted_d    = halted_q;
        // A committing halt outranks everything, including a same-edge redirect.
        if (bus.halt_commit) begin
            state_d    = StHalted;
            valid_id_d = 1'b0;
            halted_d   = 1'b1;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (bus.redirect) begin
                        pc_d       = target;
                        valid_id_d = 1'b0;
                    end else if (bus.stall) begin
                        // hold everything
                    end else if (bus.halt_if) begin
                        pc_id_d     = pc_q;
                        pc_inc_id_d = pc_inc;
                        valid_id_d  = 1'b1;
                        state_d     = StHaltWait;
                    end else begin
                        pc_d        = pc_inc;
                        pc_id_d     = pc_q;
                        pc_inc_id_d = pc_inc;
                        valid_id_d  = 1'b1;
                    end
                end
                StHaltWait: begin
                    if (bus.redirect) begin
                        pc_d       = target;
                        valid_id_d = 1'b0;
                        state_d    = StRun;
                    end else if (!bus.stall) begin
                        valid_id_d = 1'b0;
                    end
                end
                StHalted: valid_id_d = 1'b0;
                default:  state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            pc_q        <= ResetPc;
            pc_id_q     <= '0;
            pc_inc_id_q <= '0;
            valid_id_q  <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_id_q     <= pc_id_d;
            pc_inc_id_q <= pc_inc_id_d;
            valid_id_q  <= valid_id_d;
            halted_q    <= halted_d;
        end
    end

    assign bus.pc_if     = pc_q;
    assign bus.pc_inc_if = pc_inc;
    assign bus.pc_id     = pc_id_q;
    assign bus.pc_inc_id = pc_inc_id_q;
    assign bus.valid_id  = valid_id_q;
    assign bus.halted    = halted_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: expected states queued per step, popped and checked after each edge.
module tb_pc_unit;
    logic clk;
    logic rst_n;
    logic rst_nb;

    pc_unit_if #(.PC_W(16)) bus_a ();
    pc_unit_if #(.PC_W(8))  bus_b ();

    pc_unit #(.PC_W(16), .INC(2), .RESET_PC(0)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    pc_unit #(.PC_W(8), .INC(4), .RESET_PC(32'hF8)) dut_b (
        .clk   (clk),
        .rst_n (rst_nb),
        .bus   (bus_b)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] pc_if;
        logic [15:0] pc_inc_if;
        logic [15:0] pc_id;
        logic [15:0] pc_inc_id;
        logic        valid_id;
        logic        halted;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push(input string tag, input int sel, input logic [15:0] pc,
                        input logic [15:0] pc_inc, input logic [15:0] id,
                        input logic [15:0] inc_id, input logic v, input logic h);
        exp_t e;
        e.tag = tag; e.sel = sel; e.pc_if = pc; e.pc_inc_if = pc_inc;
        e.pc_id = id; e.pc_inc_id = inc_id; e.valid_id = v; e.halted = h;
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input string field, input logic [15:0] got,
                       input logic [15:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s.%s: observed %h expected %h", tag, field, got, want);
        end
    endtask

    task automatic check();
        exp_t e;
        n_assert++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end
        if (sb.size() == 0) return;
        e = sb.pop_front();
        if (e.sel == 0) begin
            cmp(e.tag, "pc_if", bus_a.pc_if, e.pc_if);
            cmp(e.tag, "pc_inc_if", bus_a.pc_inc_if, e.pc_inc_if);
            cmp(e.tag, "pc_id", bus_a.pc_id, e.pc_id);
            cmp(e.tag, "pc_inc_id", bus_a.pc_inc_id, e.pc_inc_id);
            cmp(e.tag, "valid_id", {15'd0, bus_a.valid_id}, {15'd0, e.valid_id});
            cmp(e.tag, "halted", {15'd0, bus_a.halted}, {15'd0, e.halted});
        end else begin
            cmp(e.tag, "pc_if", {8'd0, bus_b.pc_if}, e.pc_if);
            cmp(e.tag, "pc_inc_if", {8'd0, bus_b.pc_inc_if}, e.pc_inc_if);
            cmp(e.tag, "pc_id", {8'd0, bus_b.pc_id}, e.pc_id);
            cmp(e.tag, "pc_inc_id", {8'd0, bus_b.pc_inc_id}, e.pc_inc_id);
            cmp(e.tag, "valid_id", {15'd0, bus_b.valid_id}, {15'd0, e.valid_id});
            cmp(e.tag, "halted", {15'd0, bus_b.halted}, {15'd0, e.halted});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic drive_a(input logic st, input logic rd, input logic [15:0] rpc,
                           input logic hi, input logic hc);
        bus_a.stall = st; bus_a.redirect = rd; bus_a.redirect_pc = rpc;
        bus_a.halt_if = hi; bus_a.halt_commit = hc;
    endtask

    initial begin
        rst_n  = 1'b0;
        rst_nb = 1'b0;
        drive_a(0, 0, 16'h0, 0, 0);
        bus_b.stall = 0; bus_b.redirect = 0; bus_b.redirect_pc = 8'h0;
        bus_b.halt_if = 0; bus_b.halt_commit = 0;

        push("reset", 0, 16'h0, 16'h2, 16'h0, 16'h0, 0, 0);
        tick();
        rst_n = 1'b1;

        // Free-run up to pc_if = 0x10
        for (int i = 1; i <= 8; i++) begin
            push($sformatf("run%0d", i), 0, 16'(2 * i), 16'(2 * i + 2), 16'(2 * i - 2),
                 16'(2 * i), 1, 0);
            tick();
        end

        drive_a(1, 0, 16'h0, 0, 0);
        push("stall1", 0, 16'h10, 16'h12, 16'hE, 16'h10, 1, 0); tick();
        push("stall2", 0, 16'h10, 16'h12, 16'hE, 16'h10, 1, 0); tick();
        drive_a(0, 0, 16'h0, 0, 0);
        push("unstall", 0, 16'h12, 16'h14, 16'h10, 16'h12, 1, 0); tick();

        drive_a(1, 1, 16'h41, 0, 0);
        push("redir_stall", 0, 16'h40, 16'h42, 16'h10, 16'h12, 0, 0); tick();
        drive_a(0, 0, 16'h0, 0, 0);
        push("after_redir", 0, 16'h42, 16'h44, 16'h40, 16'h42, 1, 0); tick();

        drive_a(0, 1, 16'h20, 0, 0);
        push("redir_20", 0, 16'h20, 16'h22, 16'h40, 16'h42, 0, 0); tick();
        drive_a(0, 0, 16'h0, 1, 0);
        push("halt_if", 0, 16'h20, 16'h22, 16'h20, 16'h22, 1, 0); tick();
        push("halt_bubble", 0, 16'h20, 16'h22, 16'h20, 16'h22, 0, 0); tick();
        drive_a(0, 1, 16'h100, 0, 0);
        push("hw_redir", 0, 16'h100, 16'h102, 16'h20, 16'h22, 0, 0); tick();
        drive_a(0, 0, 16'h0, 0, 0);
        push("resume1", 0, 16'h102, 16'h104, 16'h100, 16'h102, 1, 0); tick();
        push("resume2", 0, 16'h104, 16'h106, 16'h102, 16'h104, 1, 0); tick();

        drive_a(0, 0, 16'h0, 1, 0);
        push("halt_if2", 0, 16'h104, 16'h106, 16'h104, 16'h106, 1, 0); tick();
        drive_a(0, 0, 16'h0, 0, 0);
        push("hw_wait1", 0, 16'h104, 16'h106, 16'h104, 16'h106, 0, 0); tick();
        push("hw_wait2", 0, 16'h104, 16'h106, 16'h104, 16'h106, 0, 0); tick();
        drive_a(0, 1, 16'h200, 0, 1);
        push("commit", 0, 16'h104, 16'h106, 16'h104, 16'h106, 0, 1); tick();
        drive_a(0, 1, 16'h300, 0, 0);
        push("halted_redir", 0, 16'h104, 16'h106, 16'h104, 16'h106, 0, 1); tick();
        drive_a(1, 1, 16'h400, 1, 0);
        push("halted_all", 0, 16'h104, 16'h106, 16'h104, 16'h106, 0, 1); tick();

        // Asynchronous reset mid-cycle
        drive_a(0, 0, 16'h0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        push("async_rst", 0, 16'h0, 16'h2, 16'h0, 16'h0, 0, 0);
        check();
        #1 rst_n = 1'b1;
        push("post_rst", 0, 16'h2, 16'h4, 16'h0, 16'h2, 1, 0); tick();

        // Narrow instance: wrap-around and redirect alignment with INC=4
        push("b_reset", 1, 16'hF8, 16'hFC, 16'h0, 16'h0, 0, 0);
        check();
        rst_nb = 1'b1;
        push("b_fc", 1, 16'hFC, 16'h00, 16'hF8, 16'hFC, 1, 0); tick();
        push("b_wrap", 1, 16'h00, 16'h04, 16'hFC, 16'h00, 1, 0); tick();
        bus_b.redirect = 1; bus_b.redirect_pc = 8'h37;
        push("b_align", 1, 16'h34, 16'h38, 16'hFC, 16'h00, 0, 0); tick();
        bus_b.redirect = 0;
        push("b_after", 1, 16'h38, 16'h3C, 16'h34, 16'h38, 1, 0); tick();

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
